rb_window_reader: RTL and testbench
===================================

RB_WINDOW_READER -- requirements
Module: rb_window_reader

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits.
REQ-002 Parameter K, default 3, window size and number of row buffers.
REQ-003 Parameter IMG_W, default 8, image width in pixels.
REQ-004 Parameter IMG_H, default 8, image height in pixels.
REQ-005 Parameter SW, default $clog2(K), steer width.
REQ-006 Port clk  in  1  single clock; all logic on rising edge.
REQ-007 Port rst_n  in  1  asynchronous, active-low reset.
REQ-008 Port start  in  1  synchronous frame restart pulse.
REQ-009 Port in_valid  in  1  a column beat is present on in_data/steer.
REQ-010 Port in_ready  out  1  the block accepts the beat this cycle.
REQ-011 Port in_data  in  K*DATA_W  one pixel from each physical row buffer; slice p = buffer p.
REQ-012 Port steer  in  SW  index of the physical buffer that holds the oldest (top) row.
REQ-013 Port win_valid  out  1  win_data holds a complete KxK window.
REQ-014 Port win_ready  in  1  downstream accepts the window.
REQ-015 Port win_data  out  K*K*DATA_W  window; element (r,c) at bits (r*K+c)*DATA_W, r=0 top row, c=0 leftmost column.
REQ-016 Port win_col  out  $clog2(IMG_W)  column index of the window's rightmost pixel.
REQ-017 Port win_row  out  $clog2(IMG_H)  row index of the window's top row.
REQ-018 Port frame_done  out  1  one-cycle pulse after the last window of the frame is accepted.
REQ-019 Port busy  out  1  high in FILL or STREAM.

Function
REQ-020 States: IDLE, FILL, STREAM, DONE; the block leaves reset in IDLE.
REQ-021 start high in any state: next cycle FILL, col_cnt=0, row_cnt=0, win_valid=0, window contents unchanged; start has priority over all other events.
REQ-022 in_ready = (state is FILL or STREAM) and (win_valid=0 or win_ready=1); in_ready=0 in IDLE and DONE.
REQ-023 Beat accepted = in_valid and in_ready; beats are ignored otherwise and upstream holds data.
REQ-024 On accept, row alignment: aligned row r = in_data slice ((steer + r) mod K); the mod SHALL be correct for non-power-of-two K.
REQ-025 On accept, the window shifts left one column; the aligned column enters at c=K-1.
REQ-026 col_cnt counts accepted beats 0..IMG_W-1, then wraps to 0 and increments row_cnt.
REQ-027 FILL: an accepted beat with col_cnt < K-1 produces no window; the beat with col_cnt = K-2 moves the block to STREAM.
REQ-028 STREAM: every accepted beat sets win_valid=1 the next cycle, with win_col=col_cnt and win_row=row_cnt of that beat; latency 1 cycle.
REQ-029 STREAM: an accepted beat with col_cnt=IMG_W-1 and row_cnt<IMG_H-K moves the block to FILL (new row, col_cnt=0).
REQ-030 The beat with col_cnt=IMG_W-1 and row_cnt=IMG_H-K is the last; the block then enters DONE.
REQ-031 win_valid clears on win_valid and win_ready with no simultaneous accept; a simultaneous accept keeps it set with new data.
REQ-032 win_data, win_col and win_row SHALL be stable while win_valid=1 and win_ready=0.
REQ-033 DONE: frame_done pulses for exactly one cycle when the final window is handed off (win_valid and win_ready); the block stays in DONE until start.
REQ-034 Per frame: (IMG_H-K+1)*IMG_W beats accepted; (IMG_H-K+1)*(IMG_W-K+1) windows emitted (defaults: 48 beats, 36 windows).

Reset
REQ-035 rst_n low asynchronously forces IDLE, in_ready=0, win_valid=0, win_data=0, win_col=0, win_row=0, frame_done=0, busy=0, and all counters to 0.
REQ-036 Reset assertion mid-frame discards the partial window; after release the block waits for start.

Verification
REQ-037 Reset, start, 48 beats with in_valid=1, win_ready=1, and pixel=(row<<4)|col -> 36 windows in raster order; first window top-left 0x00 and bottom-right 0x22; frame_done is 1 cycle after the 36th window.
REQ-038 steer cycled 0,1,2 per row with in_data rotated to match -> windows identical to steer=0 reference.
REQ-039 win_ready held low 5 cycles on the 3rd window -> in_ready=0 during those cycles; win_data is stable; no beat lost or duplicated.
REQ-040 in_valid random 50% duty, win_ready random 50% -> same 36 windows, in order.
REQ-041 start pulsed after the 20th beat -> win_valid drops next cycle; a full new frame yields 36 correct windows.
REQ-042 rst_n pulsed low mid-STREAM, asynchronous to clk -> all outputs 0 immediately; in_ready stays 0 until start.

Source files
------------

// File: rtl/rb_window_reader.sv
// rb_window_reader: builds KxK sliding windows from column beats of K row buffers,
// re-aligning the physical buffers so the oldest row always lands in window row 0.
module rb_window_reader #(
   parameter int DATA_W = 8,
   parameter int K      = 3,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int SW     = $clog2(K)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [K*DATA_W-1:0]        in_data,
   input  logic [SW-1:0]              steer,
   output logic                       win_valid,
   input  logic                       win_ready,
   output logic [K*K*DATA_W-1:0]      win_data,
   output logic [$clog2(IMG_W)-1:0]   win_col,
   output logic [$clog2(IMG_H)-1:0]   win_row,
   output logic                       frame_done,
   output logic                       busy
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
   localparam logic [CW-1:0] FILL_LAST = CW'(K - 2);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - K);

   typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

   state_t                 state;
   logic [CW-1:0]          col_cnt;
   logic [RW-1:0]          row_cnt;
   logic [K*K*DATA_W-1:0]  win_nxt;
   logic                   accept;

   assign busy     = state == FILL || state == STREAM;
   assign in_ready = busy && (!win_valid || win_ready);
   assign accept   = in_valid && in_ready;

   // modulo index keeps the rotation correct when K is not a power of two
   always_comb begin
      win_nxt = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++)
            win_nxt[(r*K+c)*DATA_W +: DATA_W] = win_data[(r*K+c+1)*DATA_W +: DATA_W];
         win_nxt[(r*K+K-1)*DATA_W +: DATA_W] = in_data[((int'(steer) + r) % K)*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         col_cnt    <= '0;
         row_cnt    <= '0;
         win_valid  <= 1'b0;
         win_data   <= '0;
         win_col    <= '0;
         win_row    <= '0;
         frame_done <= 1'b0;
      end else if (start) begin
         state      <= FILL;
         col_cnt    <= '0;
         row_cnt    <= '0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= state == DONE && win_valid && win_ready;
         if (accept) begin
            win_data  <= win_nxt;
            win_valid <= state == STREAM;
            col_cnt   <= col_cnt == COL_LAST ? '0 : col_cnt + 1'b1;
            if (col_cnt == COL_LAST && row_cnt != ROW_LAST)
               row_cnt <= row_cnt + 1'b1;
            if (state == STREAM) begin
               win_col <= col_cnt;
               win_row <= row_cnt;
            end
            if (state == FILL && col_cnt == FILL_LAST)
               state <= STREAM;
            else if (state == STREAM && col_cnt == COL_LAST)
               state <= row_cnt == ROW_LAST ? DONE : FILL;
         end else if (win_ready) begin
            win_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_rb_window_reader.sv
// tb_rb_window_reader: directed frames feed a scoreboard queue; an independent monitor
// pops and compares each window handed off by the reader.
module tb_rb_window_reader;
   localparam int DATA_W = 8;
   localparam int K      = 3;
   localparam int IMG_W  = 8;
   localparam int IMG_H  = 8;
   localparam int SW     = $clog2(K);
   localparam int BEATS  = (IMG_H - K + 1) * IMG_W;

   typedef struct {
      logic [K*K*DATA_W-1:0] d;
      int                    col;
      int                    row;
      bit                    last;
   } exp_t;

   logic                      clk = 0;
   logic                      rst_n = 0;
   logic                      start = 0;
   logic                      in_valid = 0;
   logic                      in_ready;
   logic [K*DATA_W-1:0]       in_data = '0;
   logic [SW-1:0]             steer = '0;
   logic                      win_valid;
   logic                      win_ready = 1;
   logic [K*K*DATA_W-1:0]     win_data;
   logic [$clog2(IMG_W)-1:0]  win_col;
   logic [$clog2(IMG_H)-1:0]  win_row;
   logic                      frame_done;
   logic                      busy;

   exp_t exp_q[$];
   int   total = 0, bad = 0;
   int   hs_count = 0, stall_at = -1, stall_left = 0, stall_seen = 0;
   int   wr_mode = 0;
   bit   fd_pending = 0;

   rb_window_reader #(.DATA_W(DATA_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .SW(SW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .steer(steer), .win_valid(win_valid), .win_ready(win_ready),
      .win_data(win_data), .win_col(win_col), .win_row(win_row),
      .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] pix(input int r, input int c);
      return DATA_W'((r << 4) | c);
   endfunction

   function automatic logic [K*K*DATA_W-1:0] exp_win(input int r, input int c);
      logic [K*K*DATA_W-1:0] w = '0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            w[(i*K+j)*DATA_W +: DATA_W] = pix(r + i, c - (K - 1) + j);
      return w;
   endfunction

   // physical buffer p holds image row r + ((p - s) mod K) when buffer s is the oldest
   function automatic logic [K*DATA_W-1:0] beat_data(input int r, input int c, input int s);
      logic [K*DATA_W-1:0] d = '0;
      for (int p = 0; p < K; p++)
         d[p*DATA_W +: DATA_W] = pix(r + (p - s + K) % K, c);
      return d;
   endfunction

   task automatic send_beat(input int r, input int c, input int s, input bit rnd);
      int  guard = 0;
      bit  done = 0;
      exp_t e;
      while (!done) begin
         @(negedge clk);
         in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         steer    = SW'(s);
         in_data  = beat_data(r, c, s);
         #1;
         if (in_valid && in_ready) begin
            done = 1;
            if (c >= K - 1) begin
               e.d = exp_win(r, c); e.col = c; e.row = r;
               e.last = (r == IMG_H - K) && (c == IMG_W - 1);
               exp_q.push_back(e);
            end
         end else if (++guard > 200) begin
            check("beat_timeout", 0, 1);
            done = 1;
         end
      end
   endtask

   task automatic send_beats(input int n, input bit rot, input bit rnd);
      for (int b = 0; b < n; b++)
         send_beat(b / IMG_W, b % IMG_W, rot ? (b / IMG_W) % K : 0, rnd);
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || win_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   task automatic frame(input string tag, input bit rot, input bit rnd);
      pulse_start();
      check({tag, "_busy_after_start"}, busy, 1);
      send_beats(BEATS, rot, rnd);
      drain();
      check({tag, "_done_in_ready"}, in_ready, 0);
      check({tag, "_done_busy"}, busy, 0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (wr_mode == 1)
            win_ready = 1'($urandom_range(0, 1));
         else if (wr_mode == 2 && win_valid && hs_count == stall_at && stall_left > 0) begin
            win_ready = 0;
            stall_left--;
         end else
            win_ready = 1;
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (fd_pending || frame_done) check("frame_done_pulse", frame_done, fd_pending);
         fd_pending = 0;
         if (win_valid && win_ready) begin
            if (exp_q.size() == 0) check("unexpected_window", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("win_data", win_data, e.d);
               check("win_col", win_col, e.col);
               check("win_row", win_row, e.row);
               hs_count++;
               fd_pending = e.last;
            end
         end else if (win_valid) begin
            stall_seen++;
            check("stall_in_ready", in_ready, 0);
            if (exp_q.size() != 0) check("stall_win_data", win_data, exp_q[0].d);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_win_valid", win_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_win_data", win_data, 0);
      rst_n = 1;
      in_valid = 1;
      repeat (2) @(negedge clk);
      check("idle_in_ready", in_ready, 0);
      check("idle_frame_done", frame_done, 0);
      in_valid = 0;

      frame("plain", 0, 0);
      frame("steer", 1, 0);

      stall_at = hs_count + 2; stall_left = 5; stall_seen = 0; wr_mode = 2;
      frame("stall", 0, 0);
      check("stall_cycles", stall_seen, 5);
      wr_mode = 1;
      frame("random", 1, 1);
      wr_mode = 0;

      pulse_start();
      send_beats(20, 0, 0);
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      #3;
      check("restart_win_valid", win_valid, 0);
      check("restart_busy", busy, 1);
      drain();
      frame("after_restart", 0, 0);

      pulse_start();
      for (int b = 0; b < 12; b++) send_beat(b / IMG_W, b % IMG_W, 0, 0);
      @(negedge clk);
      #3;
      rst_n = 0;
      #1;
      check("arst_win_valid", win_valid, 0);
      check("arst_in_ready", in_ready, 0);
      check("arst_busy", busy, 0);
      check("arst_win_data", win_data, 0);
      check("arst_win_col", win_col, 0);
      check("arst_win_row", win_row, 0);
      check("arst_frame_done", frame_done, 0);
      exp_q.delete();
      fd_pending = 0;
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_in_ready", in_ready, 0);
      end
      in_valid = 0;
      frame("after_reset", 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
